// File: rtl/add_subs_pkg.sv
// add_subs_pkg: shared op encoding and default width for the add/subtract accumulator
package add_subs_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_t;
endpackage

// File: rtl/add_subs_core.sv
// add_subs_core: combinational adder computing x + (m ? ~y + 1 : y) with carry and signed overflow
module add_subs_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             m,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH-1:0] yi;
  assign yi = m ? ~y : y;
  assign {cout, res} = {1'b0, x} + {1'b0, yi} + {{WIDTH{1'b0}}, m};
  assign ovf = (x[WIDTH-1] == yi[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
endmodule

// File: rtl/add_subs_acc.sv
// add_subs_acc: registered add/subtract unit with chaining accumulator and valid/ready handshakes
module add_subs_acc
  import add_subs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             zero,
  output logic             ovf
);
  logic [WIDTH-1:0] acc, x, y, res;
  logic accept, m, cout, c_ovf;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign m = (op == OP_SUB) || (op == OP_ACC_SUB);
  // a clear coinciding with an ACC op makes the accumulator operand zero
  assign x = op[1] ? (acc_clr ? '0 : acc) : a;
  assign y = op[1] ? a : b;
  add_subs_core #(.WIDTH(WIDTH)) u_core (
    .x(x), .y(y), .m(m), .res(res), .cout(cout), .ovf(c_ovf)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum <= '0;
      zero <= 1'b0;
      ovf <= 1'b0;
      acc <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      sum <= {cout, res};
      zero <= (res == '0);
      ovf <= c_ovf;
      acc <= res;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (acc_clr) acc <= '0;
    end
  end
endmodule

// File: tb/tb_add_subs_acc.sv
// tb_add_subs_acc: directed self-checking bench for add_subs_acc at WIDTH=4
module tb_add_subs_acc;
  import add_subs_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, acc_clr, out_valid, out_ready, zero, ovf;
  op_t op;
  logic [3:0] a, b;
  logic [4:0] sum;
  int tests = 0, fails = 0;
  add_subs_acc #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .zero(zero), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic present(input op_t o, input logic [3:0] va, input logic [3:0] vb);
    in_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
  endtask
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    op = OP_ADD; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({out_valid, sum, zero, ovf} !== 8'b0) begin
      fails++; $display("FAIL reset_out: got %b want %b", {out_valid, sum, zero, ovf}, 8'b0);
    end
    tests++;
    if (dut.acc !== 4'b0) begin fails++; $display("FAIL reset_acc: got %b want 0000", dut.acc); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_add_sub();
    present(OP_ADD, 4'b0011, 4'b0101);
    tick();
    tests++;
    if ({out_valid, sum, zero, ovf} !== {1'b1, 5'b01000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL add_3_5: got %b want %b", {out_valid, sum, zero, ovf}, {1'b1, 5'b01000, 1'b0, 1'b1});
    end
    tests++;
    if (dut.acc !== 4'b1000) begin fails++; $display("FAIL add_acc: got %b want 1000", dut.acc); end
    present(OP_SUB, 4'b1000, 4'b1000);
    tick();
    tests++;
    if ({out_valid, sum, zero, ovf} !== {1'b1, 5'b10000, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_8_8: got %b want %b", {out_valid, sum, zero, ovf}, {1'b1, 5'b10000, 1'b1, 1'b0});
    end
    present(OP_SUB, 4'b0001, 4'b0010);
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, sum, zero, ovf} !== {1'b1, 5'b01111, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub_1_2: got %b want %b", {out_valid, sum, zero, ovf}, {1'b1, 5'b01111, 1'b0, 1'b0});
    end
    tick();
    tests++;
    if ({out_valid, sum} !== {1'b0, 5'b01111}) begin
      fails++; $display("FAIL consume: got %b want %b", {out_valid, sum}, {1'b0, 5'b01111});
    end
  endtask
  task automatic test_acc_chain();
    logic [4:0] exp_sum [3] = '{5'b00111, 5'b01110, 5'b10101};
    logic exp_ovf [3] = '{1'b0, 1'b1, 1'b0};
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    tests++;
    if ({out_valid, dut.acc} !== 5'b0) begin
      fails++; $display("FAIL acc_clr_idle: got %b want 00000", {out_valid, dut.acc});
    end
    present(OP_ACC_ADD, 4'b0111, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({out_valid, sum, zero, ovf} !== {1'b1, exp_sum[i], 1'b0, exp_ovf[i]}) begin
        fails++; $display("FAIL acc_chain_%0d: got %b want %b", i, {out_valid, sum, zero, ovf}, {1'b1, exp_sum[i], 1'b0, exp_ovf[i]});
      end
    end
    in_valid = 1'b0;
    tests++;
    if (dut.acc !== 4'b0101) begin fails++; $display("FAIL acc_chain_final: got %b want 0101", dut.acc); end
  endtask
  task automatic test_acc_clr_sub();
    present(OP_ACC_SUB, 4'b0001, 4'b0000);
    acc_clr = 1'b1;
    tick();
    in_valid = 1'b0; acc_clr = 1'b0;
    tests++;
    if ({out_valid, sum, zero, ovf} !== {1'b1, 5'b01111, 1'b0, 1'b0}) begin
      fails++; $display("FAIL clr_sub: got %b want %b", {out_valid, sum, zero, ovf}, {1'b1, 5'b01111, 1'b0, 1'b0});
    end
    tests++;
    if (dut.acc !== 4'b1111) begin fails++; $display("FAIL clr_sub_acc: got %b want 1111", dut.acc); end
  endtask
  task automatic test_backpressure();
    tick();
    out_ready = 1'b0;
    present(OP_ADD, 4'b0001, 4'b0001);
    tick();
    present(OP_ADD, 4'b0010, 4'b0011);
    tests++;
    if ({out_valid, sum, in_ready} !== {1'b1, 5'b00010, 1'b0}) begin
      fails++; $display("FAIL bp_first: got %b want %b", {out_valid, sum, in_ready}, {1'b1, 5'b00010, 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({out_valid, sum, in_ready, dut.acc} !== {1'b1, 5'b00010, 1'b0, 4'b0010}) begin
        fails++; $display("FAIL bp_hold_%0d: got %b want %b", i, {out_valid, sum, in_ready, dut.acc}, {1'b1, 5'b00010, 1'b0, 4'b0010});
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if ({out_valid, sum, dut.acc} !== {1'b1, 5'b00101, 4'b0101}) begin
      fails++; $display("FAIL bp_second: got %b want %b", {out_valid, sum, dut.acc}, {1'b1, 5'b00101, 4'b0101});
    end
  endtask
  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, sum, zero, ovf, dut.acc} !== 12'b0) begin
      fails++; $display("FAIL reset_mid: got %b want %b", {out_valid, sum, zero, ovf, dut.acc}, 12'b0);
    end
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_ready: got %b want 1", in_ready); end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_idle: got %b want 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_acc_chain();
    test_acc_clr_sub();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_subs_acc.md
# add_subs_acc

Parametrised successor to the 4-bit add/subtract unit. It is a registered WIDTH-bit adder/subtractor with an internal accumulator, carry/zero/overflow flags, and valid/ready handshakes on input and output. It sits between the operand-select logic and the ALU result mux. It adds a chaining (accumulate) mode and backpressure, which the combinational unit does not have.

## Interface
- WIDTH, 4, operand width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op presented (replaces old `enable`)
- in_ready  output  1  unit can accept this cycle
- op  input  2  00 ADD (a+b), 01 SUB (a−b), 10 ACC_ADD (acc+a), 11 ACC_SUB (acc−a)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for ACC ops)
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream consumes result
- sum  output  WIDTH+1  {carry_out, result}; same format as the 4-bit unit
- zero  output  1  result[WIDTH-1:0] == 0
- ovf  output  1  two's-complement signed overflow

## Operation
- Accept occurs when in_valid && in_ready.
- Subtraction is computed as x + ~y + 1. sum[WIDTH] is carry out, so 1 means no borrow.
- ovf = (x[MSB] == y'[MSB]) && (res[MSB] != x[MSB]), where y' is the operand after inversion.
- On accept:
  - sum, zero and ovf are loaded into the output register.
  - out_valid is set.
  - acc is loaded with res[WIDTH-1:0] for every op, not only ACC ops. This allows chaining from ADD/SUB.
- acc_clr alone sets acc to 0.
- acc_clr on an accept cycle:
  - The ACC operand is taken as 0.
  - acc then loads the new result.
- Output register consume: out_valid && out_ready, with no accept in the same cycle, clears out_valid.
- Output register data is held while out_valid && !out_ready.
- When in_valid = 0, nothing changes except the acc_clr effect.
- No internal FSM beyond the out_valid bit: EMPTY (out_valid=0) or FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on consume without accept.
  - FULL→FULL on simultaneous consume and accept; new data replaces old.

## Timing
- Reset values: out_valid=0, sum=0, zero=0, ovf=0, acc=0. in_ready=1 after reset.
- Reset asserted mid-operation discards any pending result and the accumulator immediately, with no clock edge needed.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: 1 cycle, accept edge to out_valid/sum visible.
- Throughput: 1 op/cycle when out_ready is held high.
- Back-to-back ACC ops see the acc value from the previous accept with no bubble. Acc is written on the accept edge.
- Wrap-around: result is modulo 2^WIDTH. The carry is reported in sum[WIDTH] and is not stored in acc.

## Structure
- Shared package add_subs_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB)
  - default WIDTH constant
- Sub-module add_subs_core: combinational WIDTH-bit adder.
  - Inputs: x, y, m (invert-and-carry-in).
  - Outputs: res, cout, ovf.
  - The top holds operand select, acc, output register and handshake.
- Expected size: about 150–200 lines of RTL total.

## Test plan
All scenarios use WIDTH=4.
- ADD, a=0011, b=0101, out_ready=1 → next cycle: out_valid=1, sum=01000, zero=0, ovf=1, acc=1000.
- SUB, a=1000, b=1000 → sum=10000, zero=1, ovf=0. SUB, a=0001, b=0010 → sum=01111 (borrow), ovf=0.
- Accumulate chain:
  - Pulse acc_clr, then ACC_ADD a=0111 three times back-to-back.
  - Sums expected: 00111, 01110, 10101. ovf expected: 0, 1, 0. Final acc=0101.
- Backpressure:
  - Hold out_ready=0 and present two valid ops.
  - First op is captured; in_ready=0 and the second op is held with the FULL result stable.
  - Raise out_ready: the first result is consumed and the second is accepted in the same cycle. The second result appears next cycle.
- acc_clr with ACC_SUB, a=0001, in the same cycle (acc was 0101) → sum=01111, acc=1111.
- Reset mid-operation: assert rst while out_valid=1 and acc≠0, then check:
  - out_valid, sum, zero, ovf and acc are 0 immediately, without a clock edge.
  - in_ready=1 after release.
